// File: rtl/mtimer.sv
// Memory-mapped 64-bit machine timer: prescaled mtime, mtimecmp compare interrupt,
// sticky pending flag and a high-word shadow so split 32-bit reads of mtime stay coherent.
module mtimer #(
    parameter int ADDR_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_wstrb,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [31:0]           o_rdata,
    output logic                  o_timer_irq
);
    localparam int WW = ADDR_WIDTH - 2;
    localparam logic [WW-1:0] WORD_MTIME_LO    = WW'(3'd0);
    localparam logic [WW-1:0] WORD_MTIME_HI    = WW'(3'd1);
    localparam logic [WW-1:0] WORD_MTIMECMP_LO = WW'(3'd2);
    localparam logic [WW-1:0] WORD_MTIMECMP_HI = WW'(3'd3);
    localparam logic [WW-1:0] WORD_CTRL        = WW'(3'd4);
    localparam logic [WW-1:0] WORD_PRESCALE    = WW'(3'd5);
    localparam logic [WW-1:0] WORD_STATUS      = WW'(3'd6);
    localparam logic [PRESCALE_WIDTH-1:0] CNT_ZERO = PRESCALE_WIDTH'(1'b0);
    localparam logic [PRESCALE_WIDTH-1:0] CNT_ONE  = PRESCALE_WIDTH'(1'b1);

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [63:0]               r_mtime;
    logic [63:0]               r_mtimecmp;
    logic                      r_en;
    logic                      r_irq_en;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_count;
    logic [31:0]               r_hi_shadow;
    logic                      r_pend;

    logic [WW-1:0] w_wword;
    logic [WW-1:0] w_rword;
    logic          w_match;
    logic          w_tick;
    logic          w_wr_mtime_lo;
    logic          w_wr_mtime_hi;
    logic          w_wr_cmp_lo;
    logic          w_wr_cmp_hi;
    logic          w_wr_ctrl;
    logic          w_wr_prescale;
    logic          w_pend_clr;
    logic          w_rd_mtime_lo;
    logic [31:0]   w_rd_value;
    logic          w_unused_lsbs;

    assign w_wword       = i_waddr[ADDR_WIDTH-1:2];
    assign w_rword       = i_raddr[ADDR_WIDTH-1:2];
    assign w_unused_lsbs = ^{i_waddr[1:0], i_raddr[1:0]};
    assign w_match       = (r_mtime >= r_mtimecmp);
    assign w_tick        = r_en & (r_count == r_prescale);
    assign w_wr_mtime_lo = i_we & (w_wword == WORD_MTIME_LO);
    assign w_wr_mtime_hi = i_we & (w_wword == WORD_MTIME_HI);
    assign w_wr_cmp_lo   = i_we & (w_wword == WORD_MTIMECMP_LO);
    assign w_wr_cmp_hi   = i_we & (w_wword == WORD_MTIMECMP_HI);
    assign w_wr_ctrl     = i_we & (w_wword == WORD_CTRL);
    assign w_wr_prescale = i_we & (w_wword == WORD_PRESCALE);
    assign w_pend_clr    = i_we & (w_wword == WORD_STATUS) & i_wstrb[0] & i_wdata[0];
    assign w_rd_mtime_lo = i_re & (w_rword == WORD_MTIME_LO);

    // Timebase: a software write to either mtime word discards that cycle's tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mtime <= 64'd0;
            r_count <= CNT_ZERO;
        end else begin
            if (w_wr_mtime_lo) begin
                r_mtime <= {r_mtime[63:32], lane_merge(r_mtime[31:0], i_wdata, i_wstrb)};
            end else if (w_wr_mtime_hi) begin
                r_mtime <= {lane_merge(r_mtime[63:32], i_wdata, i_wstrb), r_mtime[31:0]};
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end else begin
                r_mtime <= r_mtime;
            end
            if (w_wr_prescale || w_tick) begin
                r_count <= CNT_ZERO;
            end else if (r_en) begin
                r_count <= r_count + CNT_ONE;
            end else begin
                r_count <= r_count;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_en        <= 1'b0;
            r_irq_en    <= 1'b0;
            r_prescale  <= CNT_ZERO;
            r_pend      <= 1'b0;
            o_timer_irq <= 1'b0;
        end else begin
            if (w_wr_cmp_lo) begin
                r_mtimecmp[31:0] <= lane_merge(r_mtimecmp[31:0], i_wdata, i_wstrb);
            end
            if (w_wr_cmp_hi) begin
                r_mtimecmp[63:32] <= lane_merge(r_mtimecmp[63:32], i_wdata, i_wstrb);
            end
            if (w_wr_ctrl && i_wstrb[0]) begin
                r_en     <= i_wdata[0];
                r_irq_en <= i_wdata[1];
            end
            if (w_wr_prescale) begin
                r_prescale <= PRESCALE_WIDTH'(lane_merge(32'(r_prescale), i_wdata, i_wstrb));
            end
            // Set beats clear so a W1C cannot hide a match that is still present.
            if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend <= 1'b0;
            end else begin
                r_pend <= r_pend;
            end
            o_timer_irq <= r_irq_en & w_match;
        end
    end

    always_comb begin
        w_rd_value = 32'd0;
        case (w_rword)
            WORD_MTIME_LO:    w_rd_value = r_mtime[31:0];
            WORD_MTIME_HI:    w_rd_value = r_hi_shadow;
            WORD_MTIMECMP_LO: w_rd_value = r_mtimecmp[31:0];
            WORD_MTIMECMP_HI: w_rd_value = r_mtimecmp[63:32];
            WORD_CTRL:        w_rd_value = {30'd0, r_irq_en, r_en};
            WORD_PRESCALE:    w_rd_value = 32'(r_prescale);
            WORD_STATUS:      w_rd_value = {31'd0, r_pend};
            default:          w_rd_value = 32'd0;
        endcase
    end

    // Reading MTIME_LO freezes the matching high word for the following MTIME_HI read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_rdata     <= 32'd0;
            r_hi_shadow <= 32'd0;
        end else begin
            o_rdata <= i_re ? w_rd_value : 32'd0;
            if (w_rd_mtime_lo) begin
                r_hi_shadow <= r_mtime[63:32];
            end
        end
    end
endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: constant-expectation vector table, directed corner
// sequences and randomized bus traffic against a register-level reference model.
module tb_mtimer;
    logic        clk = 1'b0;
    logic        rstn;
    logic        i_we;
    logic [7:0]  i_waddr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic        i_re;
    logic [7:0]  i_raddr;
    logic [31:0] o_rdata;
    logic        o_timer_irq;

    int checks = 0;
    int errors = 0;

    mtimer #(.ADDR_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata),
        .i_wstrb(i_wstrb), .i_re(i_re), .i_raddr(i_raddr), .o_rdata(o_rdata),
        .o_timer_irq(o_timer_irq)
    );

    always #5 clk = ~clk;

    // Reference model state (what software would see in each register).
    logic [63:0] m_mtime, m_cmp;
    logic        m_en, m_ie, m_pend, m_irq;
    logic [15:0] m_pre, m_cnt;
    logic [31:0] m_shadow, m_rdata;

    typedef struct {
        logic        we;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        re;
        logic [7:0]  ra;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mkv(logic we, logic [7:0] wa, logic [31:0] wd, logic [3:0] ws,
                                 logic re, logic [7:0] ra, logic [31:0] exp_rd);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ws = ws; v.re = re; v.ra = ra;
        v.exp_rd = exp_rd; v.exp_irq = 1'b0;
        return v;
    endfunction

    function automatic logic [31:0] lane_mix(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(logic [7:0] a);
        case (a[7:2])
            6'd0: return m_mtime[31:0];
            6'd1: return m_shadow;
            6'd2: return m_cmp[31:0];
            6'd3: return m_cmp[63:32];
            6'd4: return {30'd0, m_ie, m_en};
            6'd5: return {16'd0, m_pre};
            6'd6: return {31'd0, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en = 1'b0; m_ie = 1'b0; m_pend = 1'b0; m_irq = 1'b0;
        m_pre = 16'd0; m_cnt = 16'd0; m_shadow = 32'd0; m_rdata = 32'd0;
    endtask

    task automatic model_step(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                              input logic [3:0] ws, input logic re, input logic [7:0] ra);
        logic        match, tick, clr;
        logic [63:0] nt;
        logic [15:0] nc;
        logic [31:0] tmp;
        match = (m_mtime >= m_cmp);
        tick  = m_en && (m_cnt == m_pre);
        clr   = 1'b0;
        m_rdata = re ? m_read(ra) : 32'd0;
        if (re && ra[7:2] == 6'd0) m_shadow = m_mtime[63:32];
        nt = tick ? m_mtime + 64'd1 : m_mtime;
        nc = !m_en ? m_cnt : (tick ? 16'd0 : m_cnt + 16'd1);
        m_irq = m_ie & match;
        if (we) begin
            case (wa[7:2])
                6'd0: nt = {m_mtime[63:32], lane_mix(m_mtime[31:0], wd, ws)};
                6'd1: nt = {lane_mix(m_mtime[63:32], wd, ws), m_mtime[31:0]};
                6'd2: m_cmp[31:0] = lane_mix(m_cmp[31:0], wd, ws);
                6'd3: m_cmp[63:32] = lane_mix(m_cmp[63:32], wd, ws);
                6'd4: if (ws[0]) begin m_ie = wd[1]; m_en = wd[0]; end
                6'd5: begin tmp = lane_mix({16'd0, m_pre}, wd, ws); m_pre = tmp[15:0]; nc = 16'd0; end
                6'd6: clr = ws[0] & wd[0];
                default: ;
            endcase
        end
        m_pend  = match | (m_pend & ~clr);
        m_mtime = nt;
        m_cnt   = nc;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                         input logic [3:0] ws, input logic re, input logic [7:0] ra);
        i_we = we; i_waddr = wa; i_wdata = wd; i_wstrb = ws; i_re = re; i_raddr = ra;
        model_step(we, wa, wd, ws, re, ra);
        @(posedge clk);
        #1;
        check32("model_rdata", o_rdata, m_rdata);
        check32("model_irq", {31'd0, o_timer_irq}, {31'd0, m_irq});
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        cycle(1'b1, a, d, s, 1'b0, 8'h00);
    endtask
    task automatic idle();
        cycle(1'b0, 8'h00, 32'd0, 4'h0, 1'b0, 8'h00);
    endtask
    task automatic rd_exp(input string name, input logic [7:0] a, input logic [31:0] exp);
        cycle(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, a);
        check32(name, o_rdata, exp);
    endtask
    task automatic irq_exp(input string name, input logic exp);
        check32(name, {31'd0, o_timer_irq}, {31'd0, exp});
    endtask

    function automatic logic [7:0] pick_addr();
        int s;
        s = $urandom_range(0, 8);
        if (s < 8) return 8'(s * 4) | 8'($urandom_range(0, 3));
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [31:0] pick_data(logic [7:0] a);
        logic [31:0] d;
        case ($urandom_range(0, 3))
            0: d = 32'($urandom_range(0, 8));
            1: d = 32'hFFFF_FFFF;
            default: d = $urandom();
        endcase
        if (a[7:2] == 6'd5) d = d & 32'h0000_0007;
        return d;
    endfunction

    initial begin
        rstn = 1'b0; i_we = 1'b0; i_waddr = 8'h00; i_wdata = 32'd0; i_wstrb = 4'h0;
        i_re = 1'b0; i_raddr = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check32("reset_rdata", o_rdata, 32'd0);
        irq_exp("reset_irq", 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Reset values, lane masking, shadow behaviour, read-before-write.
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h04, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h08, 32'hFFFF_FFFF));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h0C, 32'hFFFF_FFFF));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h10, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h14, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h18, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h1C, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h80, 32'h0000_0000));
        vecs.push_back(mkv(1'b1, 8'h14, 32'h0000_0003, 4'hF, 1'b0, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h14, 32'h0000_0003));
        vecs.push_back(mkv(1'b1, 8'h14, 32'h0000_AB00, 4'h2, 1'b0, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h14, 32'h0000_AB03));
        vecs.push_back(mkv(1'b1, 8'h14, 32'hFFFF_0000, 4'hC, 1'b0, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h16, 32'h0000_AB03));
        vecs.push_back(mkv(1'b1, 8'h00, 32'h1234_5678, 4'hF, 1'b0, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h00, 32'h1234_5678));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h04, 32'h0000_0000));
        vecs.push_back(mkv(1'b1, 8'h04, 32'hDEAD_BEEF, 4'h5, 1'b0, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h04, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h00, 32'h1234_5678));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h04, 32'h00AD_00EF));
        vecs.push_back(mkv(1'b1, 8'h08, 32'h0000_0000, 4'hF, 1'b1, 8'h08, 32'hFFFF_FFFF));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h08, 32'h0000_0000));
        vecs.push_back(mkv(1'b1, 8'h08, 32'hFFFF_FFFF, 4'hF, 1'b0, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b1, 8'h1C, 32'h1234_5678, 4'hF, 1'b0, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b1, 8'h10, 32'h0000_0003, 4'h0, 1'b0, 8'h00, 32'h0000_0000));
        vecs.push_back(mkv(1'b0, 8'h00, 32'd0, 4'h0, 1'b1, 8'h10, 32'h0000_0000));
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ws, vecs[i].re, vecs[i].ra);
            check32($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].exp_rd);
            irq_exp($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end

        // Prescale 3: 40 enabled cycles give exactly 10 ticks, then disable freezes mtime.
        wr(8'h00, 32'd0, 4'hF); wr(8'h04, 32'd0, 4'hF);
        wr(8'h14, 32'd3, 4'hF); wr(8'h10, 32'd1, 4'hF);
        repeat (40) idle();
        rd_exp("presc_run", 8'h00, 32'd10);
        wr(8'h10, 32'd0, 4'hF);
        repeat (20) idle();
        rd_exp("presc_frozen", 8'h00, 32'd10);

        // Carry across the low word: HI returns the shadow paired with the last LO read.
        wr(8'h14, 32'd0, 4'hF); wr(8'h04, 32'd0, 4'hF);
        wr(8'h00, 32'hFFFF_FFFE, 4'hF); wr(8'h10, 32'd1, 4'hF);
        idle();
        rd_exp("carry_lo0", 8'h00, 32'hFFFF_FFFF);
        rd_exp("carry_hi0", 8'h04, 32'h0000_0000);
        rd_exp("carry_lo1", 8'h00, 32'h0000_0001);
        rd_exp("carry_hi1", 8'h04, 32'h0000_0001);
        wr(8'h10, 32'd0, 4'hF);

        // Compare at 50: irq one cycle after mtime reaches 50, drops after cmp rewrite.
        wr(8'h00, 32'd0, 4'hF); wr(8'h04, 32'd0, 4'hF);
        wr(8'h0C, 32'd0, 4'hF); wr(8'h08, 32'd50, 4'hF);
        wr(8'h18, 32'd1, 4'hF); wr(8'h10, 32'd3, 4'hF);
        for (int k = 1; k <= 51; k++) begin
            idle();
            irq_exp("irq_rise", (k == 51));
        end
        wr(8'h0C, 32'd1, 4'hF);
        irq_exp("irq_hold", 1'b1);
        idle();
        irq_exp("irq_drop", 1'b0);
        rd_exp("pend_sticky", 8'h18, 32'd1);
        wr(8'h18, 32'd1, 4'hF);
        rd_exp("pend_clear", 8'h18, 32'd0);
        wr(8'h10, 32'd0, 4'hF);

        // Partial MTIME_LO write on a tick cycle wins; W1C loses to a live match.
        wr(8'h00, 32'hABCD_0000, 4'hF); wr(8'h10, 32'd1, 4'hF);
        wr(8'h00, 32'h0000_1234, 4'h3);
        rd_exp("tick_write", 8'h00, 32'hABCD_1234);
        wr(8'h0C, 32'd0, 4'hF); wr(8'h08, 32'd0, 4'hF);
        idle();
        wr(8'h18, 32'd1, 4'hF);
        rd_exp("w1c_vs_match", 8'h18, 32'd1);
        irq_exp("irq_masked", 1'b0);

        // Asynchronous reset mid-run.
        wr(8'h10, 32'd3, 4'hF);
        idle();
        irq_exp("pre_reset_irq", 1'b1);
        rd_exp("pre_reset_ctrl", 8'h10, 32'd3);
        i_we = 1'b0; i_re = 1'b0; i_wstrb = 4'h0;
        #3;
        rstn = 1'b0;
        #1;
        check32("async_rst_rdata", o_rdata, 32'd0);
        irq_exp("async_rst_irq", 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        rd_exp("post_rst_cmp_lo", 8'h08, 32'hFFFF_FFFF);
        rd_exp("post_rst_cmp_hi", 8'h0C, 32'hFFFF_FFFF);
        rd_exp("post_rst_mtime", 8'h00, 32'd0);
        rd_exp("post_rst_ctrl", 8'h10, 32'd0);

        // Random bus traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic [7:0] wa, ra;
            wa = pick_addr();
            ra = pick_addr();
            cycle(($urandom_range(0, 2) == 0), wa, pick_data(wa), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1), ra);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
